work_loader: RTL

WORK_LOADER -- requirements
Module: work_loader

---
 rtl/work_loader_pkg.sv | 38 +++
 rtl/work_loader_shreg.sv | 38 +++
 rtl/work_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/work_loader_pkg.sv
// Shared definitions for the work loader: state encoding, payload geometry,
// field widths and the default frame start marker.
// Optional feature: WORK_LOADER_CHECKSUM_EN adds the CHECK state.
package work_loader_pkg;

  localparam int PAYLOAD_BYTES = 88;
  localparam int MIDSTATE_W    = 512;
  localparam int HEADER_W      = 96;
  localparam int WORD_W        = 32;
  localparam int SHADOW_W      = PAYLOAD_BYTES * 8;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h57;
  localparam logic [6:0] LAST_BYTE_IDX     = 7'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
`ifdef WORK_LOADER_CHECKSUM_EN
    ST_CHECK   = 2'd2,
`endif
    ST_COMMIT  = 2'd3
  } state_t;

  // Shadow layout, most significant field first (first received byte on top).
  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [HEADER_W-1:0]   header;
    logic [WORD_W-1:0]     nonce_start;
    logic [WORD_W-1:0]     nonce_end;
    logic [WORD_W-1:0]     target;
  } work_t;

  // Saturating increment so the inter-byte gap counter never wraps.
  function automatic logic [23:0] sat_inc24(input logic [23:0] v);
    return (v == 24'hFF_FFFF) ? v : v + 24'd1;
  endfunction

endpackage

// File: rtl/work_loader_shreg.sv
// Byte-shift shadow register for one work frame. Bytes enter at the bottom
// and move up, so after a full payload the first byte sits in the top byte.
// With TAP_LIVE_BYTE set, only the first 87 bytes are stored and the word
// presented on frame_word appends the byte currently on byte_in; this lets
// the owner commit in the same edge that samples the final byte. With it
// clear, all 88 bytes are stored and frame_word is the stored word.
module work_loader_shreg
  import work_loader_pkg::*;
#(
  parameter bit TAP_LIVE_BYTE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [7:0]          byte_in,
  output logic [SHADOW_W-1:0] frame_word
);

  localparam int STORE_W = TAP_LIVE_BYTE ? (SHADOW_W - 8) : SHADOW_W;

  logic [STORE_W-1:0] shadow_reg;

  // Shift one byte in on every load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
    end else if (load) begin
      shadow_reg <= {shadow_reg[STORE_W-9:0], byte_in};
    end
  end

  if (TAP_LIVE_BYTE) begin : g_live
    assign frame_word = {shadow_reg, byte_in};
  end else begin : g_stored
    assign frame_word = shadow_reg;
  end

endmodule

// File: rtl/work_loader.sv
// Work loader: parses sync-framed 88-byte work records from a byte stream
// and commits them atomically to the output fields with a new_work pulse.
// Frames stalled for TIMEOUT_CYCLES idle cycles are aborted with frame_error.
// Define WORK_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module work_loader
  import work_loader_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  new_work,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [HEADER_W-1:0]   header,
  output logic [WORD_W-1:0]     nonce_start,
  output logic [WORD_W-1:0]     nonce_end,
  output logic [WORD_W-1:0]     target,
  output logic                  busy,
  output logic                  frame_error
);

  state_t      state_reg;
  logic [6:0]  byte_cnt_reg;
  logic [23:0] gap_cnt_reg;
  logic [23:0] gap_inc;
  logic        gap_hit;
  logic        is_sync;
  logic        shift_en;
  logic        commit_now;
  work_t       frame_word;

`ifdef WORK_LOADER_CHECKSUM_EN
  localparam bit TAP_LIVE = 1'b0;
  logic [7:0] xor_reg;
`else
  localparam bit TAP_LIVE = 1'b1;
`endif

  assign gap_inc  = sat_inc24(gap_cnt_reg);
  assign gap_hit  = (gap_inc >= TIMEOUT_CYCLES);
  assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
  assign shift_en = rx_valid && (state_reg == ST_PAYLOAD);

`ifdef WORK_LOADER_CHECKSUM_EN
  // Commit when the checksum byte matches the running XOR of the payload.
  assign commit_now = rx_valid && (state_reg == ST_CHECK) && (rx_data == xor_reg);
`else
  // Commit on the final payload byte; the shadow supplies it live.
  assign commit_now = shift_en && (byte_cnt_reg == LAST_BYTE_IDX);
`endif

  work_loader_shreg #(
    .TAP_LIVE_BYTE(TAP_LIVE)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift_en),
    .byte_in   (rx_data),
    .frame_word(frame_word)
  );

`ifdef WORK_LOADER_CHECKSUM_EN
  // Running XOR of payload bytes, restarted on every accepted sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_reg <= 8'h00;
    end else if (((state_reg == ST_IDLE) || (state_reg == ST_COMMIT)) && is_sync) begin
      xor_reg <= 8'h00;
    end else if (shift_en) begin
      xor_reg <= xor_reg ^ rx_data;
    end
  end
`endif

  // Output fields load only on a good frame; new_work marks that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_work    <= 1'b0;
      midstate    <= '0;
      header      <= '0;
      nonce_start <= '0;
      nonce_end   <= '0;
      target      <= '0;
    end else begin
      new_work <= commit_now;
      if (commit_now) begin
        midstate    <= frame_word.midstate;
        header      <= frame_word.header;
        nonce_start <= frame_word.nonce_start;
        nonce_end   <= frame_word.nonce_end;
        target      <= frame_word.target;
      end
    end
  end

  // Frame FSM: sync hunt, payload count, optional checksum, commit, timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= 7'd0;
      gap_cnt_reg  <= 24'd0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state_reg)
        // COMMIT lasts one cycle and treats its input like IDLE does.
        ST_IDLE, ST_COMMIT: begin
          if (is_sync) begin
            state_reg    <= ST_PAYLOAD;
            byte_cnt_reg <= 7'd0;
            gap_cnt_reg  <= 24'd0;
            busy         <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end

        // Sync value here is ordinary data; no resynchronisation.
        ST_PAYLOAD: begin
          if (rx_valid) begin
            gap_cnt_reg <= 24'd0;
            if (byte_cnt_reg == LAST_BYTE_IDX) begin
              byte_cnt_reg <= 7'd0;
`ifdef WORK_LOADER_CHECKSUM_EN
              state_reg    <= ST_CHECK;
`else
              state_reg    <= ST_COMMIT;
`endif
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 7'd1;
            end
          end else if (gap_hit) begin
            state_reg   <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_inc;
          end
        end

`ifdef WORK_LOADER_CHECKSUM_EN
        // One checksum byte decides between commit and rejection.
        ST_CHECK: begin
          if (rx_valid) begin
            gap_cnt_reg <= 24'd0;
            if (commit_now) begin
              state_reg <= ST_COMMIT;
            end else begin
              state_reg   <= ST_IDLE;
              busy        <= 1'b0;
              frame_error <= 1'b1;
            end
          end else if (gap_hit) begin
            state_reg   <= ST_IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_inc;
          end
        end
`endif

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
